// File: rtl/four_bit_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_accumulator_pkg
// Description : Shared types, constants and the saturating add/subtract
//               helper for the four-bit result accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package four_bit_accumulator_pkg;

    // Operand is {carry/borrow, 4-bit result}
    localparam int ACC_OPERAND_W     = 5;

    // Default and bounding parameter values
    localparam int DEFAULT_ACC_WIDTH = 8;
    localparam int DEFAULT_BLOCK_LEN = 4;
    localparam int MIN_ACC_WIDTH     = 6;
    localparam int MAX_ACC_W         = 16;

    // One guard bit above the widest accumulator catches the carry-out
    localparam int SAT_W             = MAX_ACC_W + 1;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } acc_state_e;

    typedef struct packed {
        logic                 ovf;
        logic [MAX_ACC_W-1:0] value;
    } sat_res_t;

    // Saturating acc +/- operand for any accumulator width up to MAX_ACC_W.
    // The caller passes its accumulator zero-extended to MAX_ACC_W bits; the
    // returned value never exceeds 2^width-1, so bits above width are zero.
    function automatic sat_res_t sat_addsub(
        input logic [MAX_ACC_W-1:0]     acc,
        input logic [ACC_OPERAND_W-1:0] operand,
        input logic                     sub,
        input int                       width
    );
        logic [SAT_W-1:0] acc_ext;
        logic [SAT_W-1:0] op_ext;
        logic [SAT_W-1:0] max_ext;
        logic [SAT_W-1:0] raw;
        sat_res_t         res;

        acc_ext = {1'b0, acc};
        op_ext  = SAT_W'(operand);
        max_ext = (SAT_W'(1) << width) - SAT_W'(1);
        raw     = '0;
        res     = '0;

        if (sub) begin
            // Borrow past zero: clamp at the floor
            if (op_ext > acc_ext) begin
                res.ovf   = 1'b1;
                res.value = '0;
            end else begin
                raw       = acc_ext - op_ext;
                res.value = raw[MAX_ACC_W-1:0];
            end
        end else begin
            raw = acc_ext + op_ext;
            if (raw > max_ext) begin
                res.ovf   = 1'b1;
                res.value = max_ext[MAX_ACC_W-1:0];
            end else begin
                res.value = raw[MAX_ACC_W-1:0];
            end
        end
        return res;
    endfunction

endpackage : four_bit_accumulator_pkg
`default_nettype wire

// File: rtl/four_bit_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_accumulator_if
// Description : Input-result and output-total handshakes of the accumulator.
//               slave  : accumulator side (consumes results, emits totals)
//               master : environment side (streams results, takes totals)
//   in_valid_i / in_ready_o         : input result handshake
//   in_carry_i, in_sum_i, in_sub_i  : operand {carry, sum} and add/sub select
//   out_valid_o / out_ready_i       : block total handshake
//   out_data_o, out_ovf_o           : block total and sticky saturation flag
// Revision    : 1.0 - initial release
// ============================================================================
interface four_bit_accumulator_if
    import four_bit_accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH
) ();

    logic                 in_valid_i;
    logic                 in_ready_o;
    logic                 in_carry_i;
    logic [3:0]           in_sum_i;
    logic                 in_sub_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [ACC_WIDTH-1:0] out_data_o;
    logic                 out_ovf_o;

    modport slave (
        input  in_valid_i,
        output in_ready_o,
        input  in_carry_i,
        input  in_sum_i,
        input  in_sub_i,
        output out_valid_o,
        input  out_ready_i,
        output out_data_o,
        output out_ovf_o
    );

    modport master (
        output in_valid_i,
        input  in_ready_o,
        output in_carry_i,
        output in_sum_i,
        output in_sub_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_data_o,
        input  out_ovf_o
    );

endinterface : four_bit_accumulator_if
`default_nettype wire

// File: rtl/four_bit_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : four_bit_accumulator
// Description : Saturating accumulator downstream of the four-bit
//               adder/subtractor. Sums BLOCK_LEN accepted results and
//               presents the block total on a valid/ready handshake.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   clear_i : synchronous abort of the current block (drops offered input)
//   bus     : input results / output totals (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module four_bit_accumulator
    import four_bit_accumulator_pkg::*;
#(
    parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,
    parameter int BLOCK_LEN = DEFAULT_BLOCK_LEN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    four_bit_accumulator_if.slave bus
);

    localparam int                CNT_W    = $clog2(BLOCK_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLOCK_LEN - 1);

    acc_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_ovf_q, out_ovf_d;

    sat_res_t             sat_res;
    logic                 accept;
    logic                 unused_sat_bits;

    assign sat_res = sat_addsub(MAX_ACC_W'(acc_q),
                                {bus.in_carry_i, bus.in_sum_i},
                                bus.in_sub_i,
                                ACC_WIDTH);

    // Bits above ACC_WIDTH are always zero after clamping
    assign unused_sat_bits = ^sat_res.value;

    assign accept = bus.in_valid_i && (state_q == ACCUM);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;

        if (clear_i) begin
            // Abort wins over both handshakes; the offered input is dropped
            state_d    = ACCUM;
            acc_d      = '0;
            cnt_d      = '0;
            ovf_d      = 1'b0;
            out_data_d = '0;
            out_ovf_d  = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept) begin
                        acc_d = sat_res.value[ACC_WIDTH-1:0];
                        ovf_d = ovf_q | sat_res.ovf;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_LAST) begin
                            out_data_d = sat_res.value[ACC_WIDTH-1:0];
                            out_ovf_d  = ovf_q | sat_res.ovf;
                            state_d    = DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready_i) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    // Moore outputs; only reset gates ready so nothing is offered during it
    assign bus.in_ready_o  = (state_q == ACCUM) && !rst_i;
    assign bus.out_valid_o = (state_q == DONE);
    assign bus.out_data_o  = out_data_q;
    assign bus.out_ovf_o   = out_ovf_q;

endmodule : four_bit_accumulator
`default_nettype wire
